gnrc_therm2bin_stream: RTL and testbench

GNRC_THERM2BIN_STREAM -- requirements
Module: gnrc_therm2bin_stream

---
 rtl/gnrc_therm2bin_stream.sv | 111 +++++++++++
 tb/tb_gnrc_therm2bin_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gnrc_therm2bin_stream.sv
// Streaming thermometer-to-binary converter, one output register per beat with
// valid/ready flow control, per-channel illegal-code flags and a saturating error counter.
module gnrc_therm2bin_stream #(
  parameter int N    = 7,
  parameter int C    = 1,
  parameter int MODE = 0,
  parameter int CW   = 16,
  localparam int M   = $clog2(N + 1) + ((N == 1) ? 1 : 0)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [C*N-1:0]   therm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [C*M-1:0]   bin_o,
  output logic [C-1:0]     err_o,
  output logic [CW-1:0]    err_cnt_o
);

  // Index of the lowest zero bit; N when the code is all ones.
  function automatic logic [M-1:0] first_zero(input logic [N-1:0] t);
    logic [M-1:0] idx;
    idx = M'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (!t[i]) idx = M'(i);
    end
    return idx;
  endfunction

  function automatic logic [M-1:0] ones_count(input logic [N-1:0] t);
    logic [M-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = s + M'(t[i]);
    end
    return s;
  endfunction

  // A legal code is a run of ones from the LSB, so adding one clears every set bit.
  function automatic logic is_illegal(input logic [N-1:0] t);
    return (t & (t + N'(1))) != '0;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [C*M-1:0]   bin_q, bin_d;
  logic [C-1:0]     err_q, err_d;
  logic [CW-1:0]    err_cnt_q, err_cnt_d;
  logic [C*M-1:0]   bin_new;
  logic [C-1:0]     err_new;
  logic             accept;

  always_comb begin
    bin_new = '0;
    err_new = '0;
    for (int k = 0; k < C; k++) begin
      if (MODE == 0) bin_new[k*M +: M] = first_zero(therm_i[k*N +: N]);
      else           bin_new[k*M +: M] = ones_count(therm_i[k*N +: N]);
      err_new[k] = is_illegal(therm_i[k*N +: N]);
    end
  end

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    bin_d       = bin_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      bin_d       = bin_new;
      err_d       = err_new;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
    // Clear wins over a same-cycle errored beat.
    if (clr_i) begin
      err_cnt_d = '0;
    end else if (accept && (|err_new)) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      err_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bin_q       <= bin_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign bin_o       = bin_q;
  assign err_o       = err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_gnrc_therm2bin_stream.sv
// Directed and random bench for gnrc_therm2bin_stream; two instances (strict/CW=16 and
// bubble-tolerant/CW=2) share one stimulus stream.
module tb_gnrc_therm2bin_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [13:0] therm = '0;
  logic        rdy0, rdy1, ov0, ov1;
  logic [5:0]  bin0, bin1;
  logic [1:0]  err0, err1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  gnrc_therm2bin_stream #(.N(7), .C(2), .MODE(0), .CW(16)) u_strict (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .therm_i(therm), .out_valid_o(ov0), .out_ready_i(out_ready), .bin_o(bin0),
    .err_o(err0), .err_cnt_o(cnt0));

  gnrc_therm2bin_stream #(.N(7), .C(2), .MODE(1), .CW(2)) u_bubble (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .therm_i(therm), .out_valid_o(ov1), .out_ready_i(out_ready), .bin_o(bin1),
    .err_o(err1), .err_cnt_o(cnt1));

  typedef struct {
    logic [13:0] th;
    logic [5:0]  b0;
    logic [5:0]  b1;
    logic [1:0]  e;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model written independently of the RTL.
  function automatic logic [2:0] m_fz(input logic [6:0] t);
    int i;
    i = 0;
    while (i < 7 && t[i]) i++;
    return 3'(i);
  endfunction

  function automatic logic m_bad(input logic [6:0] t);
    logic ok;
    ok = (t == 7'd0);
    for (int k = 1; k <= 7; k++) if (t == 7'((1 << k) - 1)) ok = 1'b1;
    return !ok;
  endfunction

  function automatic logic [6:0] rnd_code();
    if ($urandom_range(0, 1) == 0) return 7'((1 << $urandom_range(0, 7)) - 1);
    return 7'($urandom);
  endfunction

  initial begin
    int          e0, e1;
    logic [13:0] q[$];
    logic [13:0] exp_beat;
    logic        mov;
    int          sent, got;
    logic [2:0]  exp_sat [5];

    tbl[0] = '{{7'h7F, 7'h07}, {3'd7, 3'd3}, {3'd7, 3'd3}, 2'b00};
    tbl[1] = '{{7'h00, 7'h0B}, {3'd0, 3'd2}, {3'd0, 3'd3}, 2'b01};
    tbl[2] = '{{7'h5A, 7'h00}, {3'd0, 3'd0}, {3'd4, 3'd0}, 2'b10};
    tbl[3] = '{{7'h01, 7'h7F}, {3'd1, 3'd7}, {3'd1, 3'd7}, 2'b00};
    tbl[4] = '{{7'h3F, 7'h40}, {3'd6, 3'd0}, {3'd6, 3'd1}, 2'b01};
    tbl[5] = '{{7'h7D, 7'h7E}, {3'd1, 3'd0}, {3'd6, 3'd6}, 2'b11};
    exp_sat = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};

    // Reset state
    #1 rst = 1'b1;
    step(); step();
    chk("rst_ov", {ov1, ov0}, 2'b00);
    chk("rst_rdy", {rdy1, rdy0}, 2'b11);
    chk("rst_bin", {bin1, bin0}, 12'd0);
    chk("rst_err", {err1, err0}, 4'd0);
    chk("rst_cnt", {cnt1, cnt0}, 18'd0);
    rst = 1'b0;

    // Table-driven streaming, one beat per cycle
    e0 = 0; e1 = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      therm = tbl[i].th;
      step();
      if (tbl[i].e != 2'b00) begin
        e0 = e0 + 1;
        e1 = (e1 < 3) ? e1 + 1 : 3;
      end
      chk($sformatf("tbl%0d_ov", i), {ov1, ov0}, 2'b11);
      chk($sformatf("tbl%0d_bin0", i), bin0, tbl[i].b0);
      chk($sformatf("tbl%0d_bin1", i), bin1, tbl[i].b1);
      chk($sformatf("tbl%0d_err", i), {err1, err0}, {tbl[i].e, tbl[i].e});
      chk($sformatf("tbl%0d_cnt0", i), cnt0, e0);
      chk($sformatf("tbl%0d_cnt1", i), cnt1, e1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_ov", {ov1, ov0}, 2'b00);

    // Back-pressure: A held for 3 cycles, then consumed while B loads
    in_valid = 1'b1;
    out_ready = 1'b0;
    therm = {7'h03, 7'h01};
    step();
    chk("bp_a_ov", ov0, 1'b1);
    chk("bp_a_bin", bin0, {3'd2, 3'd1});
    therm = {7'h1F, 7'h0F};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_rdy%0d", i), {rdy1, rdy0}, 2'b00);
      step();
      chk($sformatf("bp_hold%0d", i), {ov0, bin0, bin1}, {1'b1, 3'd2, 3'd1, 3'd2, 3'd1});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_open", {rdy1, rdy0}, 2'b11);
    step();
    chk("bp_b_load", {ov0, bin0, bin1}, {1'b1, 3'd5, 3'd4, 3'd5, 3'd4});
    in_valid = 1'b0;
    step();
    chk("bp_drain", ov0, 1'b0);

    // Error counter saturation and clear priority
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt", {cnt1, cnt0}, 18'd0);
    in_valid = 1'b1;
    therm = {7'h00, 7'h0B};
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat_cnt1_%0d", i), cnt1, exp_sat[i][1:0]);
      chk($sformatf("sat_cnt0_%0d", i), cnt0, i + 1);
    end
    clr = 1'b1;
    step();
    chk("clr_prio_cnt", {cnt1, cnt0}, 18'd0);
    chk("clr_prio_ov", ov0, 1'b1);
    clr = 1'b0;
    in_valid = 1'b0;
    step();

    // Asynchronous reset mid-cycle while a beat is held
    in_valid = 1'b1;
    out_ready = 1'b0;
    therm = {7'h7F, 7'h05};
    step();
    in_valid = 1'b0;
    chk("ar_held", {ov0, bin0, err0, cnt0}, {1'b1, 3'd7, 3'd1, 2'b01, 16'd1});
    #2 rst = 1'b1;
    #1;
    chk("ar_ov", {ov1, ov0}, 2'b00);
    chk("ar_rdy", {rdy1, rdy0}, 2'b11);
    chk("ar_data", {bin1, bin0, err1, err0}, 16'd0);
    chk("ar_cnt", {cnt1, cnt0}, 18'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    therm = {7'h07, 7'h03};
    step();
    chk("ar_first_beat", {ov0, bin0, err0}, {1'b1, 3'd3, 3'd2, 2'b00});
    in_valid = 1'b0;
    step();
    chk("ar_no_stale", {ov1, ov0}, 2'b00);

    // Random streaming against a scoreboard
    mov = 1'b0;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [6:0] c0, c1;
      logic       fire_in, fire_out;
      c0 = rnd_code();
      c1 = rnd_code();
      in_valid = (cyc < 380) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = (cyc < 380) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      therm = {c1, c0};
      #2;
      chk("rnd_rdy", rdy0, !mov || out_ready);
      fire_out = mov && out_ready;
      fire_in = in_valid && (!mov || out_ready);
      if (fire_out) begin
        if (q.size() == 0) begin
          chk("rnd_underflow", 32'd1, 32'd0);
        end else begin
          exp_beat = q.pop_front();
          chk("rnd_beat", {bin0[5:3], bin1[5:3], err0[1], bin0[2:0], bin1[2:0], err0[0]},
              {exp_beat[13:7], exp_beat[6:0]});
          got++;
        end
      end
      if (fire_in) begin
        q.push_back({m_fz(c1), 3'($countones(c1)), m_bad(c1),
                     m_fz(c0), 3'($countones(c0)), m_bad(c0)});
        sent++;
        mov = 1'b1;
      end else if (fire_out) begin
        mov = 1'b0;
      end
      step();
    end
    chk("rnd_count", got, sent);
    chk("rnd_empty", {ov0, 31'(q.size())}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
